// File: rtl/bimodal_predictor.sv
// Bimodal branch predictor: a table of 2-bit saturating counters indexed by low PC bits.
// It has a registered lookup port with write-first forwarding and saturating branch/mispredict statistics.
module bimodal_predictor #(
    parameter int unsigned INDEX_BITS    = 6,
    parameter int unsigned ADDR_LSB      = 2,
    parameter logic [1:0]  DEFAULT_VALUE = 2'b01,
    parameter int unsigned STAT_BITS     = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 pred_valid,
    input  logic [31:0]          pred_pc,
    output logic                 pred_out_valid,
    output logic                 pred_taken,
    output logic [1:0]           pred_count,
    input  logic                 upd_valid,
    input  logic [31:0]          upd_pc,
    input  logic                 upd_taken,
    input  logic                 upd_mispredict,
    output logic [STAT_BITS-1:0] branch_count,
    output logic [STAT_BITS-1:0] mispredict_count
);
    localparam int unsigned    ENTRIES  = 1 << INDEX_BITS;
    localparam int unsigned    IDX_MSB  = ADDR_LSB + INDEX_BITS - 1;
    localparam logic [STAT_BITS-1:0] STAT_MAX = {STAT_BITS{1'b1}};

    logic [1:0]            table_q [ENTRIES];
    logic [INDEX_BITS-1:0] pred_idx;
    logic [INDEX_BITS-1:0] upd_idx;
    logic [1:0]            upd_cur;
    logic [1:0]            upd_new;
    logic                  pred_out_valid_q;
    logic [1:0]            pred_count_q, pred_count_d;
    logic [STAT_BITS-1:0]  branch_count_q, branch_count_d;
    logic [STAT_BITS-1:0]  mispredict_count_q, mispredict_count_d;

    assign pred_idx = pred_pc[IDX_MSB:ADDR_LSB];
    assign upd_idx  = upd_pc[IDX_MSB:ADDR_LSB];

    // PC bits outside the index field are deliberately ignored (aliasing is accepted).
    logic unused_pc_bits;
    assign unused_pc_bits = ^{pred_pc[31:IDX_MSB+1], pred_pc[ADDR_LSB-1:0],
                              upd_pc[31:IDX_MSB+1], upd_pc[ADDR_LSB-1:0]};

    always_comb begin
        upd_cur            = table_q[upd_idx];
        upd_new            = upd_cur;
        pred_count_d       = pred_count_q;
        branch_count_d     = branch_count_q;
        mispredict_count_d = mispredict_count_q;

        if (upd_taken && upd_cur != 2'b11) begin
            upd_new = upd_cur + 2'd1;
        end else if (!upd_taken && upd_cur != 2'b00) begin
            upd_new = upd_cur - 2'd1;
        end

        // Write-first: a same-index update in this cycle is visible to the lookup.
        if (pred_valid) begin
            if (upd_valid && upd_idx == pred_idx) begin
                pred_count_d = upd_new;
            end else begin
                pred_count_d = table_q[pred_idx];
            end
        end

        if (upd_valid) begin
            if (branch_count_q != STAT_MAX) begin
                branch_count_d = branch_count_q + STAT_BITS'(1);
            end
            if (upd_mispredict && mispredict_count_q != STAT_MAX) begin
                mispredict_count_d = mispredict_count_q + STAT_BITS'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < ENTRIES; i++) begin
                table_q[i] <= DEFAULT_VALUE;
            end
            pred_out_valid_q   <= 1'b0;
            pred_count_q       <= 2'b00;
            branch_count_q     <= '0;
            mispredict_count_q <= '0;
        end else begin
            if (upd_valid) begin
                table_q[upd_idx] <= upd_new;
            end
            pred_out_valid_q   <= pred_valid;
            pred_count_q       <= pred_count_d;
            branch_count_q     <= branch_count_d;
            mispredict_count_q <= mispredict_count_d;
        end
    end

    assign pred_out_valid   = pred_out_valid_q;
    assign pred_count       = pred_count_q;
    assign pred_taken       = pred_count_q[1];
    assign branch_count     = branch_count_q;
    assign mispredict_count = mispredict_count_q;
endmodule

// File: tb/tb_bimodal_predictor.sv
// Directed self-checking bench for bimodal_predictor; a second instance uses 3-bit statistics to reach saturation.
module tb_bimodal_predictor;
    logic        clk = 1'b0;
    logic        reset;
    logic        pred_valid;
    logic [31:0] pred_pc;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic        upd_taken;
    logic        upd_mispredict;

    logic        pov, ptk;
    logic [1:0]  pcnt;
    logic [15:0] bcnt, mcnt;
    logic        pov3, ptk3;
    logic [1:0]  pcnt3;
    logic [2:0]  bcnt3, mcnt3;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    bimodal_predictor dut (
        .clk(clk), .reset(reset), .pred_valid(pred_valid), .pred_pc(pred_pc),
        .pred_out_valid(pov), .pred_taken(ptk), .pred_count(pcnt),
        .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
        .upd_mispredict(upd_mispredict), .branch_count(bcnt), .mispredict_count(mcnt)
    );

    bimodal_predictor #(.STAT_BITS(3)) dut3 (
        .clk(clk), .reset(reset), .pred_valid(pred_valid), .pred_pc(pred_pc),
        .pred_out_valid(pov3), .pred_taken(ptk3), .pred_count(pcnt3),
        .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
        .upd_mispredict(upd_mispredict), .branch_count(bcnt3), .mispredict_count(mcnt3)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        reset = 1'b0; pred_valid = 1'b0; pred_pc = '0;
        upd_valid = 1'b0; upd_pc = '0; upd_taken = 1'b0; upd_mispredict = 1'b0;
    endtask

    task automatic update(input logic [31:0] pc, input logic tk, input logic mp);
        idle();
        upd_valid = 1'b1; upd_pc = pc; upd_taken = tk; upd_mispredict = mp;
        step();
        idle();
    endtask

    task automatic lookup(input logic [31:0] pc);
        idle();
        pred_valid = 1'b1; pred_pc = pc;
        step();
        idle();
    endtask

    task automatic test_reset();
        idle(); reset = 1'b1; step(); step(); idle();
        total++; if (pov !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", pov); end
        total++; if (pcnt !== 2'b00) begin bad++; $display("FAIL reset_count got=%b exp=00", pcnt); end
        total++; if (ptk !== 1'b0) begin bad++; $display("FAIL reset_taken got=%b exp=0", ptk); end
        total++; if (bcnt !== 16'd0 || mcnt !== 16'd0) begin bad++; $display("FAIL reset_stats got=%0d/%0d exp=0/0", bcnt, mcnt); end
    endtask

    task automatic test_lookup();
        lookup(32'h40);
        total++; if (pov !== 1'b1 || pcnt !== 2'b01 || ptk !== 1'b0) begin bad++; $display("FAIL lookup_default got=%b/%b/%b exp=1/01/0", pov, pcnt, ptk); end
        step();
        total++; if (pov !== 1'b0 || pcnt !== 2'b01) begin bad++; $display("FAIL lookup_idle_hold got=%b/%b exp=0/01", pov, pcnt); end
    endtask

    task automatic test_saturate();
        for (int i = 0; i < 4; i++) update(32'h40, 1'b1, 1'b0);
        lookup(32'h40);
        total++; if (pcnt !== 2'b11 || ptk !== 1'b1) begin bad++; $display("FAIL sat_up got=%b/%b exp=11/1", pcnt, ptk); end
        for (int i = 0; i < 3; i++) update(32'h40, 1'b1, 1'b0);
        lookup(32'h40);
        total++; if (pcnt !== 2'b11) begin bad++; $display("FAIL sat_up_hold got=%b exp=11", pcnt); end
        for (int i = 0; i < 5; i++) update(32'h40, 1'b0, 1'b0);
        lookup(32'h40);
        total++; if (pcnt !== 2'b00 || ptk !== 1'b0) begin bad++; $display("FAIL sat_down got=%b/%b exp=00/0", pcnt, ptk); end
        update(32'h40, 1'b0, 1'b0);
        lookup(32'h40);
        total++; if (pcnt !== 2'b00) begin bad++; $display("FAIL sat_down_hold got=%b exp=00", pcnt); end
        total++; if (bcnt !== 16'd13 || mcnt !== 16'd0) begin bad++; $display("FAIL stats_after_sat got=%0d/%0d exp=13/0", bcnt, mcnt); end
    endtask

    task automatic test_forward();
        idle(); pred_valid = 1'b1; pred_pc = 32'h80; upd_valid = 1'b1; upd_pc = 32'h80; upd_taken = 1'b1;
        step();
        total++; if (pov !== 1'b1 || pcnt !== 2'b10 || ptk !== 1'b1) begin bad++; $display("FAIL fwd_same got=%b/%b/%b exp=1/10/1", pov, pcnt, ptk); end
        pred_pc = 32'h84;
        step();
        total++; if (pcnt !== 2'b01) begin bad++; $display("FAIL fwd_other_idx got=%b exp=01", pcnt); end
        pred_pc = 32'h80; upd_taken = 1'b0;
        step();
        total++; if (pcnt !== 2'b10) begin bad++; $display("FAIL fwd_dec_cumulative got=%b exp=10", pcnt); end
        idle();
        lookup(32'h80);
        total++; if (pcnt !== 2'b10) begin bad++; $display("FAIL fwd_stored got=%b exp=10", pcnt); end
    endtask

    task automatic test_alias();
        update(32'h100, 1'b1, 1'b0);
        update(32'h100, 1'b1, 1'b0);
        lookup(32'h200);
        total++; if (pcnt !== 2'b11) begin bad++; $display("FAIL alias_hit got=%b exp=11", pcnt); end
        lookup(32'h104);
        total++; if (pcnt !== 2'b01) begin bad++; $display("FAIL alias_neighbor got=%b exp=01", pcnt); end
        total++; if (bcnt !== 16'd18) begin bad++; $display("FAIL stats_before_stat_test got=%0d exp=18", bcnt); end
    endtask

    task automatic test_stats();
        idle(); reset = 1'b1; step(); idle();
        for (int i = 0; i < 10; i++) update(32'h8 + 32'(i * 4), 1'(i % 2), 1'(i < 3));
        total++; if (bcnt3 !== 3'd7 || mcnt3 !== 3'd3) begin bad++; $display("FAIL stats3_sat got=%0d/%0d exp=7/3", bcnt3, mcnt3); end
        total++; if (bcnt !== 16'd10 || mcnt !== 16'd3) begin bad++; $display("FAIL stats16 got=%0d/%0d exp=10/3", bcnt, mcnt); end
        idle(); upd_mispredict = 1'b1; step(); step(); idle();
        total++; if (bcnt !== 16'd10 || mcnt !== 16'd3) begin bad++; $display("FAIL stats_ignore_mp got=%0d/%0d exp=10/3", bcnt, mcnt); end
        total++; if (mcnt3 !== 3'd3) begin bad++; $display("FAIL stats3_ignore_mp got=%0d exp=3", mcnt3); end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 3; i++) update(32'h40, 1'b1, 1'b1);
        lookup(32'h40);
        total++; if (pcnt !== 2'b11) begin bad++; $display("FAIL mid_preload got=%b exp=11", pcnt); end
        idle(); reset = 1'b1; pred_valid = 1'b1; pred_pc = 32'h40;
        upd_valid = 1'b1; upd_pc = 32'h40; upd_taken = 1'b1; upd_mispredict = 1'b1;
        step();
        total++; if (pov !== 1'b0 || pcnt !== 2'b00) begin bad++; $display("FAIL mid_reset_out got=%b/%b exp=0/00", pov, pcnt); end
        total++; if (bcnt !== 16'd0 || mcnt !== 16'd0 || bcnt3 !== 3'd0) begin bad++; $display("FAIL mid_reset_stats got=%0d/%0d/%0d exp=0/0/0", bcnt, mcnt, bcnt3); end
        lookup(32'h40);
        total++; if (pov !== 1'b1 || pcnt !== 2'b01) begin bad++; $display("FAIL mid_post_lookup got=%b/%b exp=1/01", pov, pcnt); end
    endtask

    initial begin
        idle();
        test_reset();
        test_lookup();
        test_saturate();
        test_forward();
        test_alias();
        test_stats();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
